vending_machine: RTL and testbench
==================================

// Module: vending_machine
// PURPOSE
//  Single-transaction vending controller: 7 product slots with a per-slot price table and payment by coins or card.
//  Accumulates coin credit, dispenses when credit covers the selected slot's price, and returns change.
//  cancel refunds the full credit. Sits between coin/card front-end and the dispense/change actuators.
// PARAMETERS
//  NUM_SLOTS  7    product slots, fixed by 3-bit index (index 7 = invalid)
//  PRICE_W    9    width of every price, credit, change and card value (cents, max 511)
//  NICKEL_VAL 5    cents per nickel
//  DIME_VAL   10   cents per dime
//  QUARTER_VAL 25  cents per quarter
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-high reset
//  index          in   3   selected slot 0..6; 7 selects nothing
//  paymentMethod  in   1   0 = coins, 1 = card
//  creditBalance  in   9   card balance in cents (sampled only in card mode)
//  nickel         in   1   coin pulse, one coin per rising edge of the signal
//  dime           in   1   coin pulse
//  quarter        in   1   coin pulse
//  cost           in   63  price table; slot k price = cost[9k+8:9k]; price 0 = out of stock
//  cancel         in   1   refund request
//  change         out  9   change/refund amount, valid one cycle, else 0
//  dispensed      out  1   one-cycle dispense strobe
//  dispensed_index out 3   slot of the last dispense, updated with dispensed
// BEHAVIOUR
//  All outputs registered. rst: credit=0, state=IDLE, change=0, dispensed=0, dispensed_index=0.
//  Reset mid-transaction discards credit; no refund is emitted.
//  Coin inputs: rising-edge detected on clk (prev-sample regs, reset 0); a held level counts once.
//  Simultaneous coins in one cycle are summed (max 40).
//  price = cost slice for index; price_ok = (index!=7) && (price!=0).
//  States: IDLE (credit==0), COLLECT (credit>0), VEND, REFUND, CARD_WAIT.
//  Coin mode (paymentMethod=0), IDLE/COLLECT, per edge:
//   - sum = credit + coins. If sum > 511: coins are rejected.
//     Credit is unchanged; change = coin value for one cycle.
//   - Otherwise credit <= sum; state becomes COLLECT if credit > 0.
//   - If cancel and credit > 0: go REFUND. Cancel has priority over vend and over coins that cycle.
//     Those coins are still credited, into the next transaction.
//   - Else if price_ok and credit >= price (credit before this edge's coins): go VEND.
//     Vend latency is therefore 2 edges after the completing coin.
//  VEND (one cycle): dispensed=1, change=credit-price, dispensed_index=index; credit<=coins this cycle; go IDLE/COLLECT.
//  REFUND (one cycle): change=credit, dispensed=0; credit<=coins this cycle.
//  Empty slot or index 7: never vends; credit is held; index may change freely while collecting.
//  Price compared is always that of the current index.
//  Card mode (paymentMethod=1), only from IDLE; coins are ignored in card mode.
//   - If price_ok and creditBalance >= price: VEND with change=0, then CARD_WAIT.
//   - CARD_WAIT holds until paymentMethod=0: one vend per card session.
//   - Insufficient balance: stay IDLE, no outputs.
//  paymentMethod=1 while in COLLECT: treated as coin mode until credit returns to 0.
//  Arithmetic is unsigned 9-bit; credit can never exceed 511 and change never underflows.
// TESTING
//  Fixture: cost slots 6..0 = {150,100,200,100,0,0,0}.
//  T1: rst, index=2 (empty), 4 nickel pulses
//      -> credit 20, dispensed stays 0; cancel -> change=20 for 1 cycle.
//  T2: index=3, 4 quarter pulses
//      -> dispensed=1 for 1 cycle, 2 edges after the 4th coin; change=0, dispensed_index=3.
//  T3: index=5, 3 quarters, then dime+quarter in the same cycle -> credit 110 -> dispensed, change=10.
//  T4: paymentMethod=1, creditBalance=200, index=4
//      -> exactly one dispensed pulse, change=0; then creditBalance=150 (new session) -> no dispense.
//  T5: index=2, 20 quarters (500), then 1 quarter -> change=25 reject pulse, credit stays 500; cancel -> change=500.
//  T6: 2 dimes inserted, rst mid-collection -> all outputs 0, no change pulse; later cancel -> nothing.

Source files
------------

// File: rtl/vending_machine.sv
// ---------------------------------------------------------------------------
// vending_machine
//   Single-transaction vending controller with a 7-slot price table.
//   Payment is by coins (accumulated as credit) or by card (one vend per card
//   session). Dispenses when the payment covers the selected slot's price and
//   returns change. cancel refunds the whole coin credit.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   index           selected slot 0..6, 7 selects nothing
//   paymentMethod   0 = coins, 1 = card
//   creditBalance   card balance in cents (used only for card vends)
//   nickel/dime/quarter  coin pulses, one coin per rising edge of the level
//   cost            packed price table, slot k = cost[9k+8:9k], 0 = empty
//   cancel          refund request
//   change          change/refund amount, valid for one cycle, else 0
//   dispensed       one-cycle dispense strobe
//   dispensed_index slot of the last dispense
// ---------------------------------------------------------------------------
module vending_machine #(
  parameter int NUM_SLOTS   = 7,
  parameter int PRICE_W     = 9,
  parameter int NICKEL_VAL  = 5,
  parameter int DIME_VAL    = 10,
  parameter int QUARTER_VAL = 25
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   index,
  input  logic                         paymentMethod,
  input  logic [PRICE_W-1:0]           creditBalance,
  input  logic                         nickel,
  input  logic                         dime,
  input  logic                         quarter,
  input  logic [NUM_SLOTS*PRICE_W-1:0] cost,
  input  logic                         cancel,
  output logic [PRICE_W-1:0]           change,
  output logic                         dispensed,
  output logic [2:0]                   dispensed_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_REFUND,
    S_CARD_WAIT
  } state_t;

  localparam logic [2:0]         INVALID_IDX  = 3'd7;
  localparam logic [PRICE_W-1:0] NICKEL_AMT   = PRICE_W'(NICKEL_VAL);
  localparam logic [PRICE_W-1:0] DIME_AMT     = PRICE_W'(DIME_VAL);
  localparam logic [PRICE_W-1:0] QUARTER_AMT  = PRICE_W'(QUARTER_VAL);

  state_t               state_reg;
  logic [PRICE_W-1:0]   credit_reg;
  logic                 card_vend_reg;
  logic                 nickel_prev_reg;
  logic                 dime_prev_reg;
  logic                 quarter_prev_reg;

  // Price lookup table padded to 8 entries so every 3-bit index is in range;
  // the padding entries read as price 0 (never vendable).
  logic [PRICE_W-1:0]   slot_price [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NUM_SLOTS) begin : g_real
        assign slot_price[gi] = cost[gi*PRICE_W +: PRICE_W];
      end else begin : g_pad
        assign slot_price[gi] = '0;
      end
    end
  endgenerate

  logic [PRICE_W-1:0] price;
  logic               price_ok;
  logic               nickel_rise;
  logic               dime_rise;
  logic               quarter_rise;
  logic [PRICE_W-1:0] coin_total;
  logic [PRICE_W:0]   sum_ext;
  logic               coin_overflow;

  assign price        = slot_price[index];
  assign price_ok     = (index != INVALID_IDX) && (price != '0);

  assign nickel_rise  = nickel  & ~nickel_prev_reg;
  assign dime_rise    = dime    & ~dime_prev_reg;
  assign quarter_rise = quarter & ~quarter_prev_reg;

  always_comb begin
    coin_total = '0;
    if (nickel_rise)  coin_total = coin_total + NICKEL_AMT;
    if (dime_rise)    coin_total = coin_total + DIME_AMT;
    if (quarter_rise) coin_total = coin_total + QUARTER_AMT;
  end

  // One extra bit catches credit + coins exceeding the 9-bit range.
  assign sum_ext       = {1'b0, credit_reg} + {1'b0, coin_total};
  assign coin_overflow = sum_ext[PRICE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      credit_reg       <= '0;
      card_vend_reg    <= 1'b0;
      nickel_prev_reg  <= 1'b0;
      dime_prev_reg    <= 1'b0;
      quarter_prev_reg <= 1'b0;
      change           <= '0;
      dispensed        <= 1'b0;
      dispensed_index  <= '0;
    end else begin
      nickel_prev_reg  <= nickel;
      dime_prev_reg    <= dime;
      quarter_prev_reg <= quarter;
      // Strobes default low; each branch raises what it needs for one cycle.
      change           <= '0;
      dispensed        <= 1'b0;

      case (state_reg)
        S_IDLE, S_COLLECT: begin
          if (state_reg == S_IDLE && paymentMethod) begin
            // Card session: coins are ignored, balance is only compared.
            if (price_ok && creditBalance >= price) begin
              dispensed       <= 1'b1;
              dispensed_index <= index;
              card_vend_reg   <= 1'b1;
              state_reg       <= S_VEND;
            end
          end else if (cancel && credit_reg != '0) begin
            // Refund wins over vend; coins on this edge seed the next sale.
            change     <= credit_reg;
            credit_reg <= coin_total;
            state_reg  <= S_REFUND;
          end else if (price_ok && credit_reg >= price) begin
            // Decision uses credit before this edge's coins, which carry over.
            dispensed       <= 1'b1;
            change          <= credit_reg - price;
            dispensed_index <= index;
            credit_reg      <= coin_total;
            card_vend_reg   <= 1'b0;
            state_reg       <= S_VEND;
          end else if (coin_overflow) begin
            // Coins that would overflow credit are handed straight back.
            change <= coin_total;
          end else begin
            credit_reg <= sum_ext[PRICE_W-1:0];
            state_reg  <= (sum_ext[PRICE_W-1:0] != '0) ? S_COLLECT : S_IDLE;
          end
        end

        S_VEND, S_REFUND: begin
          if (state_reg == S_VEND && card_vend_reg) begin
            state_reg <= S_CARD_WAIT;
          end else if (coin_overflow) begin
            change    <= coin_total;
            state_reg <= (credit_reg != '0) ? S_COLLECT : S_IDLE;
          end else begin
            credit_reg <= sum_ext[PRICE_W-1:0];
            state_reg  <= (sum_ext[PRICE_W-1:0] != '0) ? S_COLLECT : S_IDLE;
          end
        end

        S_CARD_WAIT: begin
          // One vend per card session: wait for the card to be withdrawn.
          if (!paymentMethod) state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  index;
  logic        paymentMethod;
  logic [8:0]  creditBalance;
  logic        nickel, dime, quarter;
  logic [62:0] cost;
  logic        cancel;
  logic [8:0]  change;
  logic        dispensed;
  logic [2:0]  dispensed_index;

  vending_machine dut (
    .clk             (clk),
    .rst             (rst),
    .index           (index),
    .paymentMethod   (paymentMethod),
    .creditBalance   (creditBalance),
    .nickel          (nickel),
    .dime            (dime),
    .quarter         (quarter),
    .cost            (cost),
    .cancel          (cancel),
    .change          (change),
    .dispensed       (dispensed),
    .dispensed_index (dispensed_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       disp;
    logic [8:0] chg;
    logic [2:0] idx;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_disp_cyc = -1;
  int disp_count = 0;

  // Reference model state: transaction-level credit and selected slot.
  int m_credit = 0;
  int m_index  = 0;
  int fixture[8] = '{0, 0, 0, 100, 200, 100, 150, 0};

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every cycle with a visible output consumes one expected event.
  always @(negedge clk) begin
    if (!rst && (dispensed || change != 9'd0)) begin
      checks++;
      if (dispensed) begin
        last_disp_cyc = cyc;
        disp_count++;
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got disp=%0d change=%0d idx=%0d, required no output",
                 dispensed, change, dispensed_index);
      end else begin
        mon_e = exp_q.pop_front();
        if (dispensed !== mon_e.disp || change !== mon_e.chg ||
            (mon_e.disp && dispensed_index !== mon_e.idx)) begin
          errors++;
          $display("FAIL event: got disp=%0d change=%0d idx=%0d, required disp=%0d change=%0d idx=%0d",
                   dispensed, change, dispensed_index, mon_e.disp, mon_e.chg, mon_e.idx);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic int price_of(input int i);
    return fixture[i];
  endfunction

  task automatic push(input logic d, input int c, input int i);
    ev_t e;
    e.disp = d;
    e.chg  = 9'(c);
    e.idx  = 3'(i);
    exp_q.push_back(e);
  endtask

  task automatic try_vend();
    int p;
    p = price_of(m_index);
    if (p != 0 && m_credit >= p) begin
      push(1'b1, m_credit - p, m_index);
      m_credit = 0;
    end
  endtask

  int coin_drive_cyc = 0;

  task automatic do_coin(input bit n, input bit d, input bit q);
    int v;
    v = (n ? 5 : 0) + (d ? 10 : 0) + (q ? 25 : 0);
    if (m_credit + v > 511) push(1'b0, v, 0);
    else begin
      m_credit += v;
      try_vend();
    end
    coin_drive_cyc = cyc;
    nickel = n; dime = d; quarter = q;
    tick(1);
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
    tick(3);
  endtask

  task automatic do_cancel();
    if (m_credit > 0) begin
      push(1'b0, m_credit, 0);
      m_credit = 0;
    end
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    tick(3);
  endtask

  task automatic do_index(input int i);
    m_index = i;
    try_vend();
    index = 3'(i);
    tick(4);
  endtask

  // Card session from an idle machine: at most one vend while the card is in.
  task automatic do_card(input int i, input int bal, input int hold);
    int p;
    m_index = i;
    p = price_of(i);
    if (p != 0 && bal >= p) push(1'b1, 0, i);
    index = 3'(i);
    creditBalance = 9'(bal);
    paymentMethod = 1'b1;
    tick(hold);
    paymentMethod = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    chk("pending_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    tick(2);
    chk("rst_change", int'(change), 0);
    chk("rst_dispensed", int'(dispensed), 0);
    chk("rst_dispensed_index", int'(dispensed_index), 0);
    m_credit = 0;
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    int d0;
    int act;
    rst = 1'b1;
    index = 3'd0;
    paymentMethod = 1'b0;
    creditBalance = 9'd0;
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
    cancel = 1'b0;
    cost = {9'd150, 9'd100, 9'd200, 9'd100, 9'd0, 9'd0, 9'd0};
    tick(3);
    chk("reset_change", int'(change), 0);
    chk("reset_dispensed", int'(dispensed), 0);
    chk("reset_dispensed_index", int'(dispensed_index), 0);
    rst = 1'b0;
    tick(2);

    // T1: empty slot never vends; cancel refunds 20.
    do_index(2);
    repeat (4) do_coin(1'b1, 1'b0, 1'b0);
    chk("t1_no_dispense", disp_count, 0);
    do_cancel();

    // T2: exact payment, dispense two edges after the last coin.
    do_index(3);
    repeat (4) do_coin(1'b0, 1'b0, 1'b1);
    chk("t2_latency", last_disp_cyc - coin_drive_cyc, 2);
    chk("t2_disp_count", disp_count, 1);

    // T3: simultaneous dime+quarter, change 10.
    do_index(5);
    repeat (3) do_coin(1'b0, 1'b0, 1'b1);
    do_coin(1'b0, 1'b1, 1'b1);

    // T4: card vend once, then insufficient balance.
    d0 = disp_count;
    do_card(4, 200, 5);
    do_card(4, 150, 5);
    chk("t4_card_disp_count", disp_count - d0, 1);

    // T5: overflow reject then full refund of 500.
    do_index(2);
    repeat (20) do_coin(1'b0, 1'b0, 1'b1);
    do_coin(1'b0, 1'b0, 1'b1);
    do_cancel();

    // T6: reset mid-collection discards credit silently.
    repeat (2) do_coin(1'b0, 1'b1, 1'b0);
    do_reset();
    do_cancel();
    chk("t6_queue_empty", exp_q.size(), 0);

    // Randomized mix of coins, cancels, slot changes and card sessions.
    for (int s = 0; s < 500; s++) begin
      act = int'($urandom_range(0, 99));
      if (act < 60) begin
        d0 = int'($urandom_range(1, 7));
        do_coin(d0[0], d0[1], d0[2]);
      end else if (act < 70) begin
        do_cancel();
      end else if (act < 85) begin
        do_index(int'($urandom_range(0, 7)));
      end else if (act < 95 && m_credit == 0) begin
        do_card(int'($urandom_range(0, 7)), int'($urandom_range(0, 300)),
                int'($urandom_range(1, 5)));
      end else begin
        tick(2);
      end
    end

    tick(10);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
